instruction_decoder: RTL

Instruction decoder for the 8-bit CME341 microprocessor; the consumer side of the program-memory interface the program sequencer drives. It registers the instruction fetched at `pm_addr` into `ir` (aligned with `pc`), decodes it into register enables, mux selects and ALU controls, and returns `jmp`, `jmp_nz`, `dont_jmp`, `jmp_addr`, `dm_reg_en` and the four NOP flags to the sequencer. It also owns the ALU zero flag and a post-reset invalid-instruction flush.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/sat_counter.sv | 16 +
 rtl/instruction_decoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the CME341 8-bit microprocessor: opcode-class prefixes,
// destination/source codes and the reserved ALU NOP instructions.
package cpu_pkg;

  localparam logic       OP_LOAD = 1'b0;     // ir[7]
  localparam logic [1:0] OP_MOVE = 2'b10;    // ir[7:6]
  localparam logic [2:0] OP_ALU  = 3'b110;   // ir[7:5]
  localparam logic [3:0] OP_JMP  = 4'b1110;  // ir[7:4]
  localparam logic [3:0] OP_JNZ  = 4'b1111;  // ir[7:4]

  typedef enum logic [2:0] {
    DST_X0 = 3'd0,
    DST_X1 = 3'd1,
    DST_Y0 = 3'd2,
    DST_Y1 = 3'd3,
    DST_O  = 3'd4,
    DST_M  = 3'd5,
    DST_I  = 3'd6,
    DST_DM = 3'd7
  } dst_e;

  typedef enum logic [2:0] {
    SRC_X0 = 3'd0,
    SRC_X1 = 3'd1,
    SRC_Y0 = 3'd2,
    SRC_Y1 = 3'd3,
    SRC_R  = 3'd4,
    SRC_M  = 3'd5,
    SRC_I  = 3'd6,
    SRC_DM = 3'd7
  } src_e;

  localparam logic [3:0] SRC_IMM = 4'd8;

  localparam logic [7:0] NOP_C8 = 8'hC8;
  localparam logic [7:0] NOP_CF = 8'hCF;
  localparam logic [7:0] NOP_D8 = 8'hD8;
  localparam logic [7:0] NOP_DF = 8'hDF;

  function automatic logic is_nop(input logic [7:0] instr);
    return (instr == NOP_C8) || (instr == NOP_CF) ||
           (instr == NOP_D8) || (instr == NOP_DF);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 16-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= 16'h0000;
    else if (en && (count != 16'hFFFF))
      count <= count + 16'd1;
  end

endmodule

// File: rtl/instruction_decoder.sv
// Instruction register and decoder for the CME341 core; also holds the ALU zero flag.
// Optional statistics counters are built only when DECODER_STATS_EN is defined.
module instruction_decoder
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        sync_reset,
  input  logic [7:0]  pm_data,
  input  logic        alu_zero,
  output logic [7:0]  ir,
  output logic        jmp,
  output logic        jmp_nz,
  output logic [3:0]  jmp_addr,
  output logic        dont_jmp,
  output logic        NOPC8,
  output logic        NOPCF,
  output logic        NOPD8,
  output logic        NOPDF,
  output logic        x0_en,
  output logic        x1_en,
  output logic        y0_en,
  output logic        y1_en,
  output logic        o_reg_en,
  output logic        m_en,
  output logic        i_en,
  output logic        dm_reg_en,
  output logic        r_en,
  output logic [3:0]  source_sel,
  output logic        x_sel,
  output logic        y_sel,
  output logic [2:0]  alu_func,
  output logic [15:0] instr_count,
  output logic [15:0] jmp_taken_count
);

  logic       ir_valid;
  logic       dst_hit;
  dst_e       dst;
  logic [7:0] dst_en;

  // ir_valid masks the reset-cleared ir so the first post-reset cycle does nothing
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ir       <= 8'h00;
      ir_valid <= 1'b0;
    end else begin
      ir       <= pm_data;
      ir_valid <= 1'b1;
    end
  end

  always_comb begin
    dst_hit    = 1'b0;
    dst        = DST_X0;
    source_sel = SRC_IMM;
    if (ir[7] == OP_LOAD) begin
      dst_hit = 1'b1;
      dst     = dst_e'(ir[6:4]);
    end else if (ir[7:6] == OP_MOVE) begin
      dst_hit    = 1'b1;
      dst        = dst_e'(ir[5:3]);
      source_sel = {1'b0, ir[2:0]};
    end
  end

  assign dst_en = (ir_valid && dst_hit) ? (8'd1 << dst) : 8'd0;

  assign x0_en     = dst_en[DST_X0];
  assign x1_en     = dst_en[DST_X1];
  assign y0_en     = dst_en[DST_Y0];
  assign y1_en     = dst_en[DST_Y1];
  assign o_reg_en  = dst_en[DST_O];
  assign m_en      = dst_en[DST_M];
  assign i_en      = dst_en[DST_I];
  assign dm_reg_en = dst_en[DST_DM];

  assign r_en   = ir_valid && (ir[7:5] == OP_ALU) && !is_nop(ir);
  assign jmp    = ir_valid && (ir[7:4] == OP_JMP);
  assign jmp_nz = ir_valid && (ir[7:4] == OP_JNZ);

  assign NOPC8 = ir_valid && (ir == NOP_C8);
  assign NOPCF = ir_valid && (ir == NOP_CF);
  assign NOPD8 = ir_valid && (ir == NOP_D8);
  assign NOPDF = ir_valid && (ir == NOP_DF);

  assign jmp_addr = ir[3:0];
  assign x_sel    = ir[4];
  assign y_sel    = ir[3];
  assign alu_func = ir[2:0];

  always_ff @(posedge clk) begin
    if (sync_reset)
      dont_jmp <= 1'b0;
    else if (r_en)
      dont_jmp <= alu_zero;
  end

`ifdef DECODER_STATS_EN
  logic jmp_taken;
  assign jmp_taken = jmp || (jmp_nz && !dont_jmp);

  sat_counter u_instr_cnt (
    .clk   (clk),
    .clr   (sync_reset),
    .en    (ir_valid),
    .count (instr_count)
  );

  sat_counter u_jmp_cnt (
    .clk   (clk),
    .clr   (sync_reset),
    .en    (jmp_taken),
    .count (jmp_taken_count)
  );
`else
  assign instr_count     = 16'h0000;
  assign jmp_taken_count = 16'h0000;
`endif

endmodule
